// File: rtl/usb_rx_data_buffer.sv
// Receive-side byte FIFO between USB_RX and the endpoint interface.
// Stores decoded payload bytes, pops them in order on request, and flags overrun/underrun.
module usb_rx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Store_RX_Packet_Data,
  input  logic [WIDTH-1:0] RX_Packet_Data,
  input  logic             flush,
  input  logic             Get_RX_Data,
  output logic [WIDTH-1:0] RX_Data,
  output logic             RX_Data_Valid,
  output logic [CNT_W-1:0] Buffer_Occupancy,
  output logic             Buffer_Empty,
  output logic             Buffer_Full,
  output logic             Overrun,
  output logic             Underrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNT_W-1:0] occ;
  logic             is_empty;
  logic             is_full;
  logic             rd_ok;
  logic             wr_ok;
  logic             wr_blocked;
  logic             rd_blocked;

  assign is_empty = (occ == '0);
  assign is_full  = (occ == CNT_W'(DEPTH));

  // A read issued while full frees a slot, so the same-cycle write may proceed.
  assign rd_ok      = Get_RX_Data && !flush && !is_empty;
  assign wr_ok      = Store_RX_Packet_Data && !flush && (!is_full || rd_ok);
  assign wr_blocked = Store_RX_Packet_Data && !flush && !wr_ok;
  assign rd_blocked = Get_RX_Data && !flush && is_empty;

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr] <= RX_Packet_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RX_Data       <= '0;
      RX_Data_Valid <= 1'b0;
    end else begin
      RX_Data_Valid <= rd_ok;
      if (rd_ok) begin
        RX_Data <= mem[rptr];
      end
    end
  end

  // Status flags are sticky until reset or a receiver flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      Overrun  <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      if (wr_blocked) begin
        Overrun <= 1'b1;
      end
      if (rd_blocked) begin
        Underrun <= 1'b1;
      end
    end
  end

  assign Buffer_Occupancy = occ;
  assign Buffer_Empty     = is_empty;
  assign Buffer_Full      = is_full;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Self-checking bench for usb_rx_data_buffer: a directed vector table plus
// hand-written sequences for fill/overrun/wrap, flush and mid-packet reset.
module tb_usb_rx_data_buffer;

  localparam int DEPTH = 64;
  localparam int WIDTH = 8;
  localparam int CNT_W = 7;

  logic             tb_clk = 1'b0;
  logic             rst;
  logic             Store_RX_Packet_Data;
  logic [WIDTH-1:0] RX_Packet_Data;
  logic             flush;
  logic             Get_RX_Data;
  logic [WIDTH-1:0] RX_Data;
  logic             RX_Data_Valid;
  logic [CNT_W-1:0] Buffer_Occupancy;
  logic             Buffer_Empty;
  logic             Buffer_Full;
  logic             Overrun;
  logic             Underrun;

  int checks   = 0;
  int failures = 0;

  always #5 tb_clk = ~tb_clk;

  usb_rx_data_buffer #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk                 (tb_clk),
    .rst                 (rst),
    .Store_RX_Packet_Data(Store_RX_Packet_Data),
    .RX_Packet_Data      (RX_Packet_Data),
    .flush               (flush),
    .Get_RX_Data         (Get_RX_Data),
    .RX_Data             (RX_Data),
    .RX_Data_Valid       (RX_Data_Valid),
    .Buffer_Occupancy    (Buffer_Occupancy),
    .Buffer_Empty        (Buffer_Empty),
    .Buffer_Full         (Buffer_Full),
    .Overrun             (Overrun),
    .Underrun            (Underrun)
  );

  typedef struct {
    string      name;
    bit         st;
    logic [7:0] d;
    bit         g;
    bit         f;
    int         occ;
    bit         valid;
    logic [7:0] data;
    bit         over;
    bit         under;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, bit st, logic [7:0] d, bit g, bit f,
                              int occ, bit valid, logic [7:0] data, bit over, bit under);
    vec_t v;
    v.name = name; v.st = st; v.d = d; v.g = g; v.f = f;
    v.occ = occ; v.valid = valid; v.data = data; v.over = over; v.under = under;
    return v;
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against the expected state after the last edge.
  task automatic check_output(string tag, int occ, bit valid, logic [7:0] data, bit over, bit under);
    check_val({tag, " occupancy"}, 32'(Buffer_Occupancy), 32'(occ));
    check_val({tag, " empty"}, 32'(Buffer_Empty), 32'(occ == 0));
    check_val({tag, " full"}, 32'(Buffer_Full), 32'(occ == DEPTH));
    check_val({tag, " valid"}, 32'(RX_Data_Valid), 32'(valid));
    check_val({tag, " data"}, 32'(RX_Data), 32'(data));
    check_val({tag, " overrun"}, 32'(Overrun), 32'(over));
    check_val({tag, " underrun"}, 32'(Underrun), 32'(under));
  endtask

  task automatic apply_stimulus(bit r, bit st, logic [7:0] d, bit g, bit f);
    rst = r; Store_RX_Packet_Data = st; RX_Packet_Data = d; Get_RX_Data = g; flush = f;
    @(posedge tb_clk);
    #1;
    rst = 1'b0; Store_RX_Packet_Data = 1'b0; Get_RX_Data = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; Store_RX_Packet_Data = 1'b0; RX_Packet_Data = '0;
    Get_RX_Data = 1'b0; flush = 1'b0;

    vecs.push_back(mk("st_ff",        1, 8'hFF, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk("st_00",        1, 8'h00, 0, 0, 2, 0, 8'h00, 0, 0));
    vecs.push_back(mk("st_c3",        1, 8'hC3, 0, 0, 3, 0, 8'h00, 0, 0));
    vecs.push_back(mk("st_01",        1, 8'h01, 0, 0, 4, 0, 8'h00, 0, 0));
    vecs.push_back(mk("st_e7",        1, 8'hE7, 0, 0, 5, 0, 8'h00, 0, 0));
    vecs.push_back(mk("st_35",        1, 8'h35, 0, 0, 6, 0, 8'h00, 0, 0));
    vecs.push_back(mk("get_ff",       0, 8'h00, 1, 0, 5, 1, 8'hFF, 0, 0));
    vecs.push_back(mk("get_00",       0, 8'h00, 1, 0, 4, 1, 8'h00, 0, 0));
    vecs.push_back(mk("get_c3",       0, 8'h00, 1, 0, 3, 1, 8'hC3, 0, 0));
    vecs.push_back(mk("get_01",       0, 8'h00, 1, 0, 2, 1, 8'h01, 0, 0));
    vecs.push_back(mk("get_e7",       0, 8'h00, 1, 0, 1, 1, 8'hE7, 0, 0));
    vecs.push_back(mk("get_35",       0, 8'h00, 1, 0, 0, 1, 8'h35, 0, 0));
    vecs.push_back(mk("idle_hold",    0, 8'h00, 0, 0, 0, 0, 8'h35, 0, 0));
    vecs.push_back(mk("sim_empty",    1, 8'h11, 1, 0, 1, 0, 8'h35, 0, 1));
    vecs.push_back(mk("after_sim",    0, 8'h00, 0, 0, 1, 0, 8'h35, 0, 1));
    vecs.push_back(mk("flush",        0, 8'h00, 0, 1, 0, 0, 8'h35, 0, 0));
    vecs.push_back(mk("flush_st_get", 1, 8'h22, 1, 1, 0, 0, 8'h35, 0, 0));
    vecs.push_back(mk("get_empty",    0, 8'h00, 1, 0, 0, 0, 8'h35, 0, 1));
    vecs.push_back(mk("st_33",        1, 8'h33, 0, 0, 1, 0, 8'h35, 0, 1));
    vecs.push_back(mk("get_33",       0, 8'h00, 1, 0, 0, 1, 8'h33, 0, 1));

    @(posedge tb_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    check_output("reset", 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      apply_stimulus(1'b0, vecs[i].st, vecs[i].d, vecs[i].g, vecs[i].f);
      check_output(vecs[i].name, vecs[i].occ, vecs[i].valid, vecs[i].data, vecs[i].over, vecs[i].under);
    end

    // Fill to capacity, then stream through while full, overrun, and drain across the wrap.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      check_val($sformatf("fill_%0d occupancy", i), 32'(Buffer_Occupancy), 32'(i + 1));
    end
    check_output("full", 64, 0, 8'h33, 0, 1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_output("clear_flags", 0, 0, 8'h33, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    end
    check_output("refill", 64, 0, 8'h33, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      check_output($sformatf("sim_full_%0d", i), 64, 1, 8'(i), 0, 0);
    end
    apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    check_output("overrun", 64, 0, 8'h09, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check_output($sformatf("drain_%0d", i), 63 - i, 1, 8'(8'h0A + i), 1, 0);
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("drain_under", 0, 0, 8'h49, 1, 1);

    // Flush with bytes pending and both flags set; the same-cycle store must vanish.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    end
    check_output("five_stored", 5, 0, 8'h49, 1, 1);
    apply_stimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    check_output("flush_busy", 0, 0, 8'h49, 0, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("post_flush_get", 0, 0, 8'h49, 0, 1);
    apply_stimulus(1'b0, 1'b1, 8'h78, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("no_77", 0, 1, 8'h78, 0, 1);

    // Reset in the middle of a packet, with activity on the strobes.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    end
    check_output("mid_packet", 20, 0, 8'h78, 0, 1);
    apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    check_output("mid_reset", 0, 0, 8'h00, 0, 0);
    apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    check_output("store_5a", 1, 0, 8'h00, 0, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_output("get_5a", 0, 1, 8'h5A, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
